gate_access_ctrl: RTL and testbench
===================================

Name: gate_access_ctrl

Overview:
Sequencer for the parking-gate front end. It consumes card-reader verdicts and vehicle sensors, tracks lot occupancy, drives the barrier, and generates the 2-bit word-select that the display-word multiplexer turns into FULL/STOP/PASS/FAIL. It sits between the card/sensor inputs and the display mux/decoder chain.

Parameters:
CAPACITY, 8, number of spaces; lot_full when occupancy equals this value (must be ≥1 and ≤ 2^CNT_W-1)
CNT_W, 4, width of occupancy counter
OPEN_TICKS, 100, clock cycles the barrier stays open waiting for car_passed (≥2)
FAIL_TICKS, 50, clock cycles FAIL is shown after a rejected card (≥2)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
card_valid  input  1  1-cycle pulse: card accepted by reader
card_invalid  input  1  1-cycle pulse: card rejected by reader
car_passed  input  1  1-cycle pulse: vehicle crossed entry sensor
car_exit  input  1  1-cycle pulse: vehicle left through exit
display_sel  output  2  word select to display mux: 00 FULL, 01 STOP, 10 PASS, 11 FAIL
gate_open  output  1  barrier open command
occupancy  output  CNT_W  vehicles currently inside
lot_full  output  1  occupancy == CAPACITY

Behaviour:
- One clock domain. Reset is asynchronous and active-low; rst_n low forces: state IDLE, display_sel=01, gate_open=0, occupancy=0, lot_full=0, timer=0. Deassertion is synchronised externally.
- All outputs registered; an input sampled at edge N is reflected on outputs after edge N (1-cycle latency).
- States: IDLE, OPEN, FAIL.
- IDLE: display_sel = 00 if lot_full, else 01; gate_open=0.
  - card_invalid → FAIL, timer loaded FAIL_TICKS-1. card_invalid wins if asserted with card_valid.
  - card_valid and not lot_full → OPEN, timer loaded OPEN_TICKS-1.
  - card_valid and lot_full → stay IDLE, display stays 00; the request is dropped.
- OPEN: display_sel=10, gate_open=1; timer decrements each cycle.
  - car_passed → occupancy+1, go IDLE. If the increment would exceed CAPACITY, occupancy saturates at CAPACITY.
  - timer==0 without car_passed → IDLE, occupancy unchanged.
  - car_passed on the timer==0 cycle counts as a pass.
  - Card pulses are ignored.
- FAIL: display_sel=11, gate_open=0; timer decrements; at timer==0 → IDLE. Card pulses are ignored (no re-trigger).
- car_exit is honoured in every state: occupancy-1, saturating at 0 (car_exit at 0 is ignored).
- car_passed with car_exit in the same cycle while in OPEN: occupancy unchanged, go IDLE.
- car_passed outside OPEN is ignored.
- lot_full is updated in the same edge as occupancy. The IDLE display reflects the new occupancy on the edge that enters IDLE.
- Reset mid-OPEN or mid-FAIL aborts immediately: gate closes and occupancy is cleared.

Optional Feature:
FAIL_LOCKOUT_EN.
- Defined: a 2-bit counter of consecutive card_invalid events is added; it clears on any card_valid accepted into OPEN. The 3rd consecutive reject loads the timer with 4*FAIL_TICKS-1 instead of FAIL_TICKS-1 and clears the counter. An extra output, lockout (1 bit), is high during that extended FAIL; it resets to 0.
- Undefined: no counter and no lockout port; every reject holds FAIL_TICKS cycles.

Test Plan:
- Reset with rst_n low asynchronously mid-cycle → display_sel=01, gate_open=0, occupancy=0 immediately, without waiting for a clock edge.
- card_valid at cycle 10, car_passed at cycle 20 → display_sel=10 and gate_open=1 from cycle 11; occupancy=1, display_sel=01, gate_open=0 after cycle 20.
- card_valid, no car_passed → gate_open high exactly 100 cycles, then 01 with occupancy unchanged.
- Eight valid entries (CAPACITY=8) → lot_full=1, display_sel=00; further card_valid keeps 00 and gate_open=0; one car_exit → occupancy=7, display_sel=01.
- card_valid and card_invalid in the same cycle → display_sel=11 for 50 cycles, then 01; card_valid during FAIL is ignored.
- car_exit at occupancy 0 → stays 0. car_passed with car_exit in OPEN at occupancy 3 → stays 3, IDLE. With FAIL_LOCKOUT_EN, three rejects → third FAIL lasts 200 cycles and lockout=1.

Source files
------------

// File: rtl/gate_access_ctrl.sv
// Parking-gate entry sequencer: card verdicts and vehicle sensors in, barrier, occupancy and display word-select out.
// Optional consecutive-reject lockout is enabled by defining FAIL_LOCKOUT_EN.
module gate_access_ctrl #(
  parameter int CAPACITY   = 8,
  parameter int CNT_W      = 4,
  parameter int OPEN_TICKS = 100,
  parameter int FAIL_TICKS = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             card_valid,
  input  logic             card_invalid,
  input  logic             car_passed,
  input  logic             car_exit,
  output logic [1:0]       display_sel,
  output logic             gate_open,
  output logic [CNT_W-1:0] occupancy,
`ifdef FAIL_LOCKOUT_EN
  output logic             lockout,
`endif
  output logic             lot_full
);

  localparam int TMR_MAX = (OPEN_TICKS > 4 * FAIL_TICKS) ? OPEN_TICKS : 4 * FAIL_TICKS;
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_TICKS - 1);
  localparam logic [TMR_W-1:0] FAIL_LOAD = TMR_W'(FAIL_TICKS - 1);
`ifdef FAIL_LOCKOUT_EN
  localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(4 * FAIL_TICKS - 1);
`endif
  localparam logic [CNT_W-1:0] CAP_C     = CNT_W'(CAPACITY);

  localparam logic [1:0] DISP_FULL = 2'b00;
  localparam logic [1:0] DISP_STOP = 2'b01;
  localparam logic [1:0] DISP_PASS = 2'b10;
  localparam logic [1:0] DISP_FAIL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OPEN,
    ST_FAIL
  } state_t;

  state_t           r_state;
  logic [TMR_W-1:0] r_timer;
  logic [1:0]       r_display_sel;
  logic             r_gate_open;
  logic [CNT_W-1:0] r_occupancy;
  logic             r_lot_full;
`ifdef FAIL_LOCKOUT_EN
  logic [1:0]       r_fail_cnt;
  logic             r_lockout;
`endif

  logic             w_pass;
  logic [CNT_W-1:0] w_occ_next;
  logic             w_full_next;
  logic [1:0]       w_idle_disp;

  assign w_pass = (r_state == ST_OPEN) && car_passed;

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_occ_next = r_occupancy;
    if (w_pass && !car_exit) begin
      if (r_occupancy < CAP_C) w_occ_next = r_occupancy + CNT_W'(1);
    end else if (!w_pass && car_exit && (r_occupancy != '0)) begin
      w_occ_next = r_occupancy - CNT_W'(1);
    end
    w_full_next = (w_occ_next == CAP_C);
    w_idle_disp = w_full_next ? DISP_FULL : DISP_STOP;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      r_display_sel <= DISP_STOP;
      r_gate_open   <= 1'b0;
      r_occupancy   <= '0;
      r_lot_full    <= 1'b0;
`ifdef FAIL_LOCKOUT_EN
      r_fail_cnt    <= 2'd0;
      r_lockout     <= 1'b0;
`endif
    end else begin
      r_occupancy <= w_occ_next;
      r_lot_full  <= w_full_next;
      case (r_state)
        ST_IDLE: begin
          r_gate_open <= 1'b0;
          if (card_invalid) begin
            r_state       <= ST_FAIL;
            r_display_sel <= DISP_FAIL;
`ifdef FAIL_LOCKOUT_EN
            if (r_fail_cnt == 2'd2) begin
              r_timer    <= LOCK_LOAD;
              r_fail_cnt <= 2'd0;
              r_lockout  <= 1'b1;
            end else begin
              r_timer    <= FAIL_LOAD;
              r_fail_cnt <= r_fail_cnt + 2'd1;
            end
`else
            r_timer       <= FAIL_LOAD;
`endif
          end else if (card_valid && !r_lot_full) begin
            r_state       <= ST_OPEN;
            r_timer       <= OPEN_LOAD;
            r_display_sel <= DISP_PASS;
            r_gate_open   <= 1'b1;
`ifdef FAIL_LOCKOUT_EN
            r_fail_cnt    <= 2'd0;
`endif
          end else begin
            r_display_sel <= w_idle_disp;
          end
        end
        ST_OPEN: begin
          if (car_passed || (r_timer == '0)) begin
            r_state       <= ST_IDLE;
            r_display_sel <= w_idle_disp;
            r_gate_open   <= 1'b0;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        ST_FAIL: begin
          if (r_timer == '0) begin
            r_state       <= ST_IDLE;
            r_display_sel <= w_idle_disp;
`ifdef FAIL_LOCKOUT_EN
            r_lockout     <= 1'b0;
`endif
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_display_sel <= w_idle_disp;
          r_gate_open   <= 1'b0;
        end
      endcase
    end
  end

  assign display_sel = r_display_sel;
  assign gate_open   = r_gate_open;
  assign occupancy   = r_occupancy;
  assign lot_full    = r_lot_full;
`ifdef FAIL_LOCKOUT_EN
  assign lockout     = r_lockout;
`endif

endmodule

// File: tb/tb_gate_access_ctrl.sv
// Self-checking bench for gate_access_ctrl: directed vector table, corner sequences, random run against a cycle-count model.
// Define FAIL_LOCKOUT_EN for both RTL and bench to cover the lockout extension.
module tb_gate_access_ctrl;

  localparam int CAPACITY   = 8;
  localparam int CNT_W      = 4;
  localparam int OPEN_TICKS = 100;
  localparam int FAIL_TICKS = 50;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             card_valid = 1'b0;
  logic             card_invalid = 1'b0;
  logic             car_passed = 1'b0;
  logic             car_exit = 1'b0;
  logic [1:0]       display_sel;
  logic             gate_open;
  logic [CNT_W-1:0] occupancy;
  logic             lot_full;
`ifdef FAIL_LOCKOUT_EN
  logic             lockout;
`endif

  always #5 clk = ~clk;

  gate_access_ctrl #(
    .CAPACITY  (CAPACITY),
    .CNT_W     (CNT_W),
    .OPEN_TICKS(OPEN_TICKS),
    .FAIL_TICKS(FAIL_TICKS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .card_valid  (card_valid),
    .card_invalid(card_invalid),
    .car_passed  (car_passed),
    .car_exit    (car_exit),
    .display_sel (display_sel),
    .gate_open   (gate_open),
    .occupancy   (occupancy),
`ifdef FAIL_LOCKOUT_EN
    .lockout     (lockout),
`endif
    .lot_full    (lot_full)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the barrier and the reject display are remaining-cycle counts.
  int m_occ, m_open_left, m_fail_left, m_rejects;
  bit m_lock;

  task automatic model_reset();
    m_occ = 0; m_open_left = 0; m_fail_left = 0; m_rejects = 0; m_lock = 0;
  endtask

  task automatic model_step(input bit v, input bit inv, input bit p, input bit e);
    bit pass_ok, was_full;
    pass_ok  = (m_open_left > 0) && p;
    was_full = (m_occ == CAPACITY);
    if (pass_ok && !e) m_occ = (m_occ < CAPACITY) ? m_occ + 1 : CAPACITY;
    else if (!pass_ok && e && m_occ > 0) m_occ = m_occ - 1;
    if (m_open_left > 0) begin
      m_open_left = pass_ok ? 0 : m_open_left - 1;
    end else if (m_fail_left > 0) begin
      m_fail_left = m_fail_left - 1;
      if (m_fail_left == 0) m_lock = 0;
    end else if (inv) begin
`ifdef FAIL_LOCKOUT_EN
      if (m_rejects == 2) begin
        m_fail_left = 4 * FAIL_TICKS; m_lock = 1; m_rejects = 0;
      end else begin
        m_fail_left = FAIL_TICKS; m_rejects = m_rejects + 1;
      end
`else
      m_fail_left = FAIL_TICKS;
`endif
    end else if (v && !was_full) begin
      m_open_left = OPEN_TICKS;
      m_rejects = 0;
    end
  endtask

  task automatic compare_model(input string tag);
    int exp_disp;
    exp_disp = (m_open_left > 0) ? 2 : (m_fail_left > 0) ? 3 : (m_occ == CAPACITY) ? 0 : 1;
    check({tag, ".disp"}, display_sel, exp_disp);
    check({tag, ".gate"}, gate_open, (m_open_left > 0) ? 1 : 0);
    check({tag, ".occ"}, occupancy, m_occ);
    check({tag, ".full"}, lot_full, (m_occ == CAPACITY) ? 1 : 0);
`ifdef FAIL_LOCKOUT_EN
    check({tag, ".lock"}, lockout, m_lock ? 1 : 0);
`endif
  endtask

  // Inputs change on the falling edge; outputs are read on the following falling edge.
  task automatic tick(input bit v, input bit inv, input bit p, input bit e);
    card_valid = v; card_invalid = inv; car_passed = p; car_exit = e;
    @(posedge clk);
    model_step(v, inv, p, e);
    @(negedge clk);
    card_valid = 0; card_invalid = 0; car_passed = 0; car_exit = 0;
  endtask

  typedef struct {
    bit         v, inv, p, e;
    logic [1:0] disp;
    bit         gate;
    int         occ;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    vecs[0]  = '{0, 0, 0, 0, 2'b01, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 2'b10, 1, 0};
    vecs[2]  = '{0, 0, 0, 0, 2'b10, 1, 0};
    vecs[3]  = '{0, 0, 1, 0, 2'b01, 0, 1};
    vecs[4]  = '{0, 0, 0, 1, 2'b01, 0, 0};
    vecs[5]  = '{0, 0, 0, 1, 2'b01, 0, 0};
    vecs[6]  = '{0, 0, 1, 0, 2'b01, 0, 0};
    vecs[7]  = '{1, 0, 0, 0, 2'b10, 1, 0};
    vecs[8]  = '{0, 0, 1, 1, 2'b01, 0, 0};
    vecs[9]  = '{1, 1, 0, 0, 2'b11, 0, 0};
    vecs[10] = '{1, 0, 0, 0, 2'b11, 0, 0};

    repeat (3) @(negedge clk);
    check("reset.disp", display_sel, 1);
    check("reset.gate", gate_open, 0);
    check("reset.occ", occupancy, 0);
    check("reset.full", lot_full, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      tick(vecs[i].v, vecs[i].inv, vecs[i].p, vecs[i].e);
      check($sformatf("vec%0d.disp", i), display_sel, vecs[i].disp);
      check($sformatf("vec%0d.gate", i), gate_open, vecs[i].gate);
      check($sformatf("vec%0d.occ", i), occupancy, vecs[i].occ);
    end

    // Reject display length; card_valid during FAIL must not re-open the barrier.
    n = 2;
    for (int g = 0; g < 100 && display_sel == 2'b11; g++) begin
      tick((m_fail_left > 1) && (g % 5 == 0), 0, 0, 0);
      if (display_sel == 2'b11) n++;
    end
    check("fail_len", n, FAIL_TICKS);
    check("after_fail.disp", display_sel, 1);
    check("after_fail.gate", gate_open, 0);

    // Entry with the vehicle crossing ten cycles later.
    tick(1, 0, 0, 0);
    check("entry.disp", display_sel, 2);
    check("entry.gate", gate_open, 1);
    for (int g = 0; g < 9; g++) begin
      tick(0, 0, 0, 0);
      compare_model("entry_wait");
    end
    tick(0, 0, 1, 0);
    check("entry_pass.occ", occupancy, 1);
    check("entry_pass.disp", display_sel, 1);
    check("entry_pass.gate", gate_open, 0);

    // Barrier timeout with no vehicle.
    tick(1, 0, 0, 0);
    n = gate_open ? 1 : 0;
    for (int g = 0; g < 300 && gate_open; g++) begin
      tick(0, 0, 0, 0);
      if (gate_open) n++;
    end
    check("open_len", n, OPEN_TICKS);
    check("timeout.occ", occupancy, 1);
    check("timeout.disp", display_sel, 1);

    // Fill the lot, attempt entry while full, then free one space.
    for (int k = 0; k < CAPACITY - 1; k++) begin
      tick(1, 0, 0, 0);
      tick(0, 0, 1, 0);
    end
    check("full.occ", occupancy, CAPACITY);
    check("full.flag", lot_full, 1);
    check("full.disp", display_sel, 0);
    tick(1, 0, 0, 0);
    check("full_req.gate", gate_open, 0);
    check("full_req.disp", display_sel, 0);
    tick(0, 0, 0, 1);
    check("exit.occ", occupancy, CAPACITY - 1);
    check("exit.disp", display_sel, 1);
    check("exit.flag", lot_full, 0);

    // Simultaneous pass and exit at occupancy 3.
    repeat (4) tick(0, 0, 0, 1);
    tick(1, 0, 0, 0);
    tick(0, 0, 1, 1);
    check("pass_exit.occ", occupancy, 3);
    check("pass_exit.disp", display_sel, 1);
    check("pass_exit.gate", gate_open, 0);

    // Asynchronous reset in the middle of an OPEN cycle.
    tick(1, 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.disp", display_sel, 1);
    check("async_rst.gate", gate_open, 0);
    check("async_rst.occ", occupancy, 0);
    check("async_rst.full", lot_full, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare_model("post_rst");

`ifdef FAIL_LOCKOUT_EN
    // Three consecutive rejects: third one holds four times longer with lockout.
    for (int r = 0; r < 3; r++) begin
      tick(0, 1, 0, 0);
      compare_model($sformatf("reject%0d", r));
      n = 1;
      for (int g = 0; g < 400 && display_sel == 2'b11; g++) begin
        tick(0, 0, 0, 0);
        if (display_sel == 2'b11) n++;
        if (g == 10) check($sformatf("reject%0d.lock", r), lockout, (r == 2) ? 1 : 0);
      end
      check($sformatf("reject%0d.len", r), n, (r == 2) ? 4 * FAIL_TICKS : FAIL_TICKS);
    end
    check("lock_end.lock", lockout, 0);
`endif

    // Random traffic against the model.
    for (int t = 0; t < 3000; t++) begin
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 23) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
      compare_model($sformatf("rand%0d", t));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
